// File: rtl/instr_fetch_reg.sv
// Fetch-side instruction register: owns the PC, fetches over imem req/ack, latches IR + PC, decodes MIPS fields.
// Latency: imem_req 1 cycle after leaving IDLE/HOLD; ir_valid 1 cycle after imem_ack; 3 cycles/instr with 1-cycle ack.
// Backpressure: stall freezes IR in HOLD and blocks new requests; redirect drops IR and squashes an in-flight fetch.
module instr_fetch_reg #(
  parameter int unsigned             DATA_W   = 32,
  parameter int unsigned             ADDR_W   = 32,
  parameter int unsigned             PC_STEP  = 4,
  parameter logic [ADDR_W-1:0]       RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ir_valid,
  output logic [DATA_W-1:0] ir,
  output logic [ADDR_W-1:0] ir_pc,
  output logic [5:0]        opcode,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [15:0]       imm16
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;
  logic                valid_q, valid_d;
  // Set when a redirect lands while a request is outstanding: the matching ack must be thrown away.
  logic                squash_q, squash_d;

  // Next-state and register updates; redirect outranks both ack and stall.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = req_q;
    addr_d   = addr_q;
    ir_d     = ir_q;
    ir_pc_d  = ir_pc_q;
    valid_d  = valid_q;
    squash_d = squash_q;

    unique case (state_q)
      S_IDLE: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end else if (en) begin
          state_d = S_FETCH;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end
      end

      S_FETCH: begin
        if (imem_ack) begin
          // The request completes either way, so the handshake always closes here.
          req_d    = 1'b0;
          squash_d = 1'b0;
          if (redirect || squash_q) begin
            // Returned word belongs to the abandoned path; restart from pc via IDLE.
            state_d = S_IDLE;
            valid_d = 1'b0;
            if (redirect) begin
              pc_d = redirect_pc;
            end
          end else begin
            state_d = S_HOLD;
            ir_d    = imem_rdata;
            ir_pc_d = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + ADDR_W'(PC_STEP);
          end
        end else if (redirect) begin
          // Keep req/addr steady so memory sees an unbroken handshake; drop its answer later.
          pc_d     = redirect_pc;
          valid_d  = 1'b0;
          squash_d = 1'b1;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          state_d = S_IDLE;
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end else if (!stall) begin
          valid_d = 1'b0;
          if (en) begin
            state_d = S_FETCH;
            req_d   = 1'b1;
            addr_d  = pc_q;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
      ir_q     <= '0;
      ir_pc_q  <= '0;
      valid_q  <= 1'b0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      ir_q     <= ir_d;
      ir_pc_q  <= ir_pc_d;
      valid_q  <= valid_d;
      squash_q <= squash_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign ir_valid  = valid_q;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;

  // Decoded fields are pure slices of the low 32 bits of IR.
  assign opcode = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign shamt  = ir_q[10:6];
  assign funct  = ir_q[5:0];
  assign imm16  = ir_q[15:0];

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Bench for instr_fetch_reg: directed scenarios then random en/stall/redirect/ack-latency traffic.
// Reference model tracks expected PC, IR contents and which fetches are discarded, at transaction level.
// Memory model acks each request after a chosen latency with an address-derived word.
module tb_instr_fetch_reg;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en, stall, redirect, imem_ack;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, ir_valid;
  logic [31:0] imem_addr, ir, ir_pc;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;

  // Second instance for the PC wrap scenario.
  logic        w_en, w_stall, w_redirect, w_ack;
  logic [31:0] w_redirect_pc, w_rdata;
  logic        w_req, w_ir_valid;
  logic [31:0] w_addr, w_ir, w_ir_pc;
  logic [5:0]  w_opcode, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_shamt;
  logic [15:0] w_imm16;

  instr_fetch_reg u_dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc),
    .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm16(imm16)
  );

  instr_fetch_reg #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .en(w_en),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ack(w_ack), .imem_rdata(w_rdata),
    .stall(w_stall), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
    .ir_valid(w_ir_valid), .ir(w_ir), .ir_pc(w_ir_pc),
    .opcode(w_opcode), .rs(w_rs), .rt(w_rt), .rd(w_rd), .shamt(w_shamt), .funct(w_funct), .imm16(w_imm16)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Memory contents: fixed load word at 0, scrambled address elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C22_0004;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Reference model state.
  logic [31:0] m_pc, m_ir, m_irpc, addr_prev;
  bit          m_valid, pend, dirty, req_prev;
  int          wait_cnt;
  int          fix_lat;

  task automatic model_reset(input logic [31:0] rpc);
    m_pc = rpc; m_ir = '0; m_irpc = '0; m_valid = 0;
    pend = 0; dirty = 0; req_prev = 0; addr_prev = '0; wait_cnt = 0;
  endtask

  // Compare outputs against the model and track request starts.
  task automatic observe();
    chk("ir_valid", {31'b0, ir_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("ir", ir, m_ir);
      chk("ir_pc", ir_pc, m_irpc);
      chk("opcode", {26'b0, opcode}, {26'b0, m_ir[31:26]});
      chk("rs_rt_rd", {17'b0, rs, rt, rd}, {17'b0, m_ir[25:11]});
      chk("shamt_funct", {21'b0, shamt, funct}, {21'b0, m_ir[10:0]});
      chk("imm16", {16'b0, imm16}, {16'b0, m_ir[15:0]});
      chk("req_in_hold", {31'b0, imem_req}, 32'h0);
    end
    if (imem_req && !req_prev) begin
      chk("req_addr", imem_addr, m_pc);
      pend = 1; dirty = 0;
      wait_cnt = (fix_lat >= 0) ? fix_lat : int'($urandom_range(0, 2));
    end else if (imem_req && req_prev) begin
      chk("addr_stable", imem_addr, addr_prev);
      if (!pend) chk("req_after_ack", {31'b0, imem_req}, 32'h0);
    end
    req_prev  = imem_req;
    addr_prev = imem_addr;
  endtask

  // One clock: drive inputs, advance model, clock, observe on the falling edge.
  task automatic step(input bit e, input bit st, input bit rdr, input logic [31:0] tgt);
    bit ack;
    ack = pend && (wait_cnt == 0);
    if (pend && !ack) wait_cnt--;
    en = e; stall = st; redirect = rdr; redirect_pc = tgt; imem_ack = ack;
    imem_rdata = ack ? mem_word(addr_prev) : $urandom;
    if (rdr) begin
      m_pc = tgt; m_valid = 0;
      if (pend) dirty = 1;
    end else if (m_valid && !st) begin
      m_valid = 0;
    end
    if (ack) begin
      pend = 0;
      if (!dirty) begin
        m_ir = imem_rdata; m_irpc = m_pc; m_pc = m_pc + 32'd4; m_valid = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    imem_ack = 1'b0; redirect = 1'b0;
    observe();
  endtask

  initial begin
    rst_n = 1'b0; en = 0; stall = 0; redirect = 0; redirect_pc = '0; imem_ack = 0; imem_rdata = '0;
    w_en = 0; w_stall = 0; w_redirect = 0; w_redirect_pc = '0; w_ack = 0; w_rdata = '0;
    fix_lat = 1;
    model_reset(32'h0);
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, ir_valid}, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_ir_pc", ir_pc, 32'h0);
    chk("rst_fields", {opcode, rs, rt, rd, shamt, funct}, 32'h0);
    chk("rst_imm16", {16'b0, imm16}, 32'h0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
    chk("rst_wrap_fields", {w_opcode, w_rs, w_rt, w_rd, w_shamt, w_funct}, 32'h0);
    rst_n = 1'b1;

    // First fetch with 1-cycle ack of the load word at 0
    step(1, 0, 0, 0);
    chk("t1_req", {31'b0, imem_req}, 32'h1);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("t1_valid", {31'b0, ir_valid}, 32'h1);
    chk("t1_ir_pc", ir_pc, 32'h0);
    chk("t1_opcode", {26'b0, opcode}, 32'h23);
    chk("t1_rs", {27'b0, rs}, 32'h1);
    chk("t1_rt", {27'b0, rt}, 32'h2);
    chk("t1_imm16", {16'b0, imm16}, 32'h4);

    // Stall holds IR for 5 cycles, no request
    repeat (5) step(1, 1, 0, 0);
    chk("t2_ir_frozen", ir, 32'h8C22_0004);
    chk("t2_no_req", {31'b0, imem_req}, 32'h0);
    step(1, 0, 0, 0);
    chk("t2_next_addr", imem_addr, 32'h4);

    // Fetch at 4, then request at 8 and redirect before its ack
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t3_addr8", imem_addr, 32'h8);
    step(1, 0, 1, 32'h100);
    chk("t3_req_held", {31'b0, imem_req}, 32'h1);
    chk("t3_addr_held", imem_addr, 32'h8);
    step(1, 0, 0, 0);
    chk("t3_dropped", {31'b0, ir_valid}, 32'h0);
    step(1, 0, 0, 0);
    chk("t3_new_addr", imem_addr, 32'h100);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("t3_ir_pc", ir_pc, 32'h100);

    // Redirect coincident with ack
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 32'h200);
    chk("t4_dropped", {31'b0, ir_valid}, 32'h0);
    step(1, 0, 0, 0);
    chk("t4_new_addr", imem_addr, 32'h200);

    // Asynchronous reset mid-fetch, then a stray ack
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req_async", {31'b0, imem_req}, 32'h0);
    chk("t6_valid_async", {31'b0, ir_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; en = 0; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    @(negedge clk);
    imem_ack = 1'b0;
    chk("t6_stray_req", {31'b0, imem_req}, 32'h0);
    chk("t6_stray_valid", {31'b0, ir_valid}, 32'h0);
    chk("t6_stray_ir", ir, 32'h0);
    model_reset(32'h0);

    // Random traffic
    fix_lat = -1;
    for (int i = 0; i < 800; i++) begin
      bit e, st, rdr;
      logic [31:0] tgt;
      e   = ($urandom_range(0, 9) != 0);
      st  = ($urandom_range(0, 2) == 0);
      rdr = ($urandom_range(0, 11) == 0);
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      step(e, st, rdr, tgt);
    end

    // PC wrap on the second instance
    w_en = 1'b1;
    for (int i = 0; i < 10 && !w_req; i++) @(negedge clk);
    chk("t5_req", {31'b0, w_req}, 32'h1);
    chk("t5_addr", w_addr, 32'hFFFF_FFFC);
    w_ack = 1'b1; w_rdata = 32'h2001_0005;
    @(posedge clk);
    @(negedge clk);
    w_ack = 1'b0;
    chk("t5_valid", {31'b0, w_ir_valid}, 32'h1);
    chk("t5_ir_pc", w_ir_pc, 32'hFFFF_FFFC);
    chk("t5_ir", w_ir, 32'h2001_0005);
    for (int i = 0; i < 10 && !w_req; i++) @(negedge clk);
    chk("t5_wrap_req", {31'b0, w_req}, 32'h1);
    chk("t5_wrap_addr", w_addr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
